// File: rtl/instr_seq.sv
// Multi-cycle fetch/decode/execute control sequencer over a shared instruction/data bus.
// Optional retired-instruction counter enabled by defining INSTR_SEQ_PERF_EN.
module instr_seq #(
  parameter logic [31:0] RESET_IR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        bus_req,
  output logic        bus_we,
  output logic        bus_is_data,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic [31:0] ir,
  input  logic        cond_true,
  output logic        alu_src_imm,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        retire,
  output logic        illegal,
  output logic [31:0] instret
);

  localparam logic [6:0] OP_NOP    = 7'b0000000;
  localparam logic [6:0] OP_ARITH  = 7'b0110011;
  localparam logic [6:0] OP_ARITHI = 7'b0010011;
  localparam logic [6:0] OP_LDUI   = 7'b0110111;
  localparam logic [6:0] OP_LDUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BR     = 7'b1100011;
  localparam logic [6:0] OP_BRR    = 7'b1101011;
  localparam logic [6:0] OP_LD     = 7'b0000011;
  localparam logic [6:0] OP_ST     = 7'b0100011;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_REL = 2'b01;
  localparam logic [1:0] PC_REG = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_BUS = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_UPI = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic        illegal_q, illegal_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        cls_legal;
  logic        cls_mem;

  assign opcode  = ir_q[6:0];
  assign funct3  = ir_q[14:12];
  assign ir      = ir_q;
  assign illegal = illegal_q;

  // Instruction class: legal/illegal, and whether it needs a bus data phase
  always_comb begin
    cls_legal = 1'b0;
    cls_mem   = 1'b0;
    case (opcode)
      OP_NOP, OP_ARITH, OP_ARITHI, OP_LDUI, OP_LDUIPC,
      OP_JAL, OP_JALR, OP_BR, OP_BRR: cls_legal = 1'b1;
      OP_LD: begin
        cls_mem = 1'b1;
        case (funct3)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: cls_legal = 1'b1;
          default:                                cls_legal = 1'b0;
        endcase
      end
      OP_ST: begin
        cls_mem = 1'b1;
        case (funct3)
          3'b000, 3'b001, 3'b010: cls_legal = 1'b1;
          default:                cls_legal = 1'b0;
        endcase
      end
      default: cls_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      ir_q      <= RESET_IR;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  // Next state and per-phase control decode
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    illegal_d   = illegal_q;
    bus_req     = 1'b0;
    bus_we      = 1'b0;
    bus_is_data = 1'b0;
    alu_src_imm = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = PC_SEQ;
    rf_we       = 1'b0;
    wb_sel      = WB_ALU;
    retire      = 1'b0;

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        bus_req = 1'b1;
        if (bus_ack) begin
          ir_d    = bus_rdata;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        if (!cls_legal)   state_d = S_TRAP;
        else if (cls_mem) state_d = S_MEM;
        else              state_d = S_EXEC;
      end

      S_EXEC: begin
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
        case (opcode)
          OP_ARITH:  rf_we = 1'b1;
          OP_ARITHI: begin rf_we = 1'b1; alu_src_imm = 1'b1; end
          OP_LDUI:   begin rf_we = 1'b1; wb_sel = WB_UPI; end
          OP_LDUIPC: begin rf_we = 1'b1; alu_src_imm = 1'b1; end
          OP_JAL:    begin rf_we = 1'b1; wb_sel = WB_PC4; pc_sel = PC_REL; end
          OP_JALR: begin
            rf_we       = 1'b1;
            wb_sel      = WB_PC4;
            alu_src_imm = 1'b1;
            pc_sel      = PC_REG;
          end
          OP_BR:     pc_sel = cond_true ? PC_REL : PC_SEQ;
          OP_BRR: begin
            alu_src_imm = 1'b1;
            pc_sel      = cond_true ? PC_REG : PC_SEQ;
          end
          default:   pc_sel = PC_SEQ;
        endcase
      end

      // Address/direction held stable until the bus completes the transfer
      S_MEM: begin
        bus_req     = 1'b1;
        bus_is_data = 1'b1;
        bus_we      = (opcode == OP_ST);
        alu_src_imm = 1'b1;
        if (bus_ack) begin
          pc_we   = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
          if (opcode == OP_LD) begin
            rf_we  = 1'b1;
            wb_sel = WB_BUS;
          end
        end
      end

      S_TRAP: illegal_d = 1'b1;

      default: state_d = S_IDLE;
    endcase
  end

`ifdef INSTR_SEQ_PERF_EN
  logic [31:0] instret_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         instret_q <= 32'd0;
    else if (retire) instret_q <= instret_q + 32'd1;
  end

  assign instret = instret_q;
`else
  assign instret = 32'd0;
`endif

endmodule

// File: tb/tb_instr_seq.sv
// Randomized self-checking bench for instr_seq against a transaction-level trace model.
module tb_instr_seq;

  logic        clk;
  logic        rst;
  logic        bus_req, bus_we, bus_is_data, bus_ack;
  logic [31:0] bus_rdata;
  logic [31:0] ir;
  logic        cond_true;
  logic        alu_src_imm, pc_we, rf_we, retire, illegal;
  logic [1:0]  pc_sel, wb_sel;
  logic [31:0] instret;

  instr_seq dut (
    .clk(clk), .rst(rst),
    .bus_req(bus_req), .bus_we(bus_we), .bus_is_data(bus_is_data),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .ir(ir), .cond_true(cond_true),
    .alu_src_imm(alu_src_imm), .pc_we(pc_we), .pc_sel(pc_sel), .rf_we(rf_we),
    .wb_sel(wb_sel), .retire(retire), .illegal(illegal), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int exp_ret = 0;
  logic cur_cond;

  logic [10:0] obs;
  logic [10:0] exp_q[$];
  logic [10:0] obs_q[$];
  logic        ack_q[$];
  logic [31:0] rd_q[$];
  int          cyc_q[$];

  // Output vector: {req, we, is_data, imm, pc_we, pc_sel, rf_we, wb_sel, retire}
  function automatic logic [10:0] vec(input logic req, input logic we, input logic isd,
                                      input logic imm, input logic pcw, input logic [1:0] pcs,
                                      input logic rfw, input logic [1:0] wbs, input logic ret);
    return {req, we, isd, imm, pcw, pcs, rfw, wbs, ret};
  endfunction

  // 0 = single-cycle execute, 1 = memory transfer, 2 = illegal
  function automatic int classify(input logic [31:0] ins);
    logic [2:0] f3;
    f3 = ins[14:12];
    case (ins[6:0])
      7'h00, 7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h6B: return 0;
      7'h03: return (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) ? 2 : 1;
      7'h23: return (f3 <= 3'd2) ? 1 : 2;
      default: return 2;
    endcase
  endfunction

  function automatic logic [10:0] exec_out(input logic [31:0] ins, input logic c);
    case (ins[6:0])
      7'h33: return vec(0, 0, 0, 0, 1, 2'b00, 1, 2'b00, 1);
      7'h13: return vec(0, 0, 0, 1, 1, 2'b00, 1, 2'b00, 1);
      7'h37: return vec(0, 0, 0, 0, 1, 2'b00, 1, 2'b11, 1);
      7'h17: return vec(0, 0, 0, 1, 1, 2'b00, 1, 2'b00, 1);
      7'h6F: return vec(0, 0, 0, 0, 1, 2'b01, 1, 2'b10, 1);
      7'h67: return vec(0, 0, 0, 1, 1, 2'b10, 1, 2'b10, 1);
      7'h63: return vec(0, 0, 0, 0, 1, c ? 2'b01 : 2'b00, 0, 2'b00, 1);
      7'h6B: return vec(0, 0, 0, 1, 1, c ? 2'b10 : 2'b00, 0, 2'b00, 1);
      default: return vec(0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 1);
    endcase
  endfunction

  function automatic logic [10:0] mem_out(input logic [31:0] ins, input logic ack);
    logic ld;
    ld = (ins[6:0] == 7'h03);
    return vec(1, !ld, 1, 1, ack, 2'b00, ack & ld, (ack & ld) ? 2'b01 : 2'b00, ack);
  endfunction

  function automatic logic noise_ack(input logic tie);
    return tie ? 1'b1 : 1'($urandom_range(0, 1));
  endfunction

  // Expected cycle trace starting at the FETCH cycle of one instruction
  function automatic void build_trace(input logic [31:0] ins, input int fw, input int mw,
                                      input logic c, input logic tie);
    exp_q.delete(); ack_q.delete(); rd_q.delete();
    cur_cond = c;
    for (int i = 0; i <= fw; i++) begin
      exp_q.push_back(vec(1, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0));
      ack_q.push_back(i == fw);
      rd_q.push_back(i == fw ? ins : 32'($urandom));
    end
    exp_q.push_back(11'd0); ack_q.push_back(noise_ack(tie)); rd_q.push_back(32'($urandom));
    case (classify(ins))
      0: begin
        exp_q.push_back(exec_out(ins, c)); ack_q.push_back(noise_ack(tie));
        rd_q.push_back(32'($urandom));
      end
      1: for (int i = 0; i <= mw; i++) begin
        exp_q.push_back(mem_out(ins, i == mw)); ack_q.push_back(i == mw);
        rd_q.push_back(32'($urandom));
      end
      default: for (int i = 0; i < 12; i++) begin
        exp_q.push_back(11'd0); ack_q.push_back(noise_ack(tie));
        rd_q.push_back(32'($urandom));
      end
    endcase
  endfunction

  task automatic step(input logic a, input logic [31:0] d, input logic c);
    @(negedge clk);
    bus_ack = a; bus_rdata = d; cond_true = c;
    #1;
    obs = {bus_req, bus_we, bus_is_data, alu_src_imm, pc_we, pc_sel, rf_we, wb_sel, retire};
    cyc++;
  endtask

  // Drives the prepared trace and records observations; no checking here
  task automatic run_trace();
    obs_q.delete(); cyc_q.delete();
    foreach (exp_q[i]) begin
      step(ack_q[i], rd_q[i], cur_cond);
      obs_q.push_back(obs);
      cyc_q.push_back(cyc);
      if (exp_q[i][0]) exp_ret++;
    end
  endtask

  function automatic logic [31:0] instret_exp();
`ifdef INSTR_SEQ_PERF_EN
    return 32'(exp_ret);
`else
    return 32'd0;
`endif
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; bus_ack = 1'b0; cond_true = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_ret = 0;
    cyc = 1;
  endtask

  function automatic logic [31:0] rand_legal();
    logic [31:0] ins;
    logic [6:0]  ops[11];
    int          k;
    ops = '{7'h00, 7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h6B, 7'h03, 7'h23};
    ins = 32'($urandom);
    k = int'($urandom_range(0, 10));
    ins[6:0] = ops[k];
    if (ops[k] == 7'h03) begin
      ins[14:12] = 3'($urandom_range(0, 4));
      if (ins[14:12] == 3'd3) ins[14:12] = 3'd5;
    end else if (ops[k] == 7'h23) begin
      ins[14:12] = 3'($urandom_range(0, 2));
    end
    return ins;
  endfunction

  task automatic test_reset();
    rst = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0; cond_true = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk); bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk); #1;
    obs = {bus_req, bus_we, bus_is_data, alu_src_imm, pc_we, pc_sel, rf_we, wb_sel, retire};
    n_cmp++; if (obs !== 11'd0) begin n_fail++; $display("FAIL reset_outputs got %b want 0", obs); end
    n_cmp++; if (ir !== 32'h0) begin n_fail++; $display("FAIL reset_ir got %h want 0", ir); end
    n_cmp++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL reset_illegal got %b want 0", illegal); end
    n_cmp++; if (instret !== 32'h0) begin n_fail++; $display("FAIL reset_instret got %h want 0", instret); end
    @(negedge clk); rst = 1'b0; exp_ret = 0; cyc = 1; #1;
    obs = {bus_req, bus_we, bus_is_data, alu_src_imm, pc_we, pc_sel, rf_we, wb_sel, retire};
    n_cmp++; if (obs !== 11'd0) begin n_fail++; $display("FAIL idle_outputs got %b want 0", obs); end
  endtask

  task automatic test_arith_tied_ack();
    int rcyc[$];
    for (int n = 0; n < 4; n++) begin
      build_trace(32'h0000_0033, 0, 0, 1'b0, 1'b1);
      run_trace();
      foreach (exp_q[i]) begin
        n_cmp++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL arith n%0d c%0d got %b want %b", n, i, obs_q[i], exp_q[i]);
        end
        if (obs_q[i][0]) rcyc.push_back(cyc_q[i]);
      end
    end
    n_cmp++;
    if (rcyc.size() != 4) begin n_fail++; $display("FAIL arith_retire_count got %0d want 4", rcyc.size()); end
    else begin
      n_cmp++; if (rcyc[0] != 4) begin n_fail++; $display("FAIL arith_first_retire got %0d want 4", rcyc[0]); end
      for (int i = 1; i < 4; i++) begin
        n_cmp++;
        if (rcyc[i] - rcyc[i-1] != 3) begin
          n_fail++; $display("FAIL arith_retire_gap got %0d want 3", rcyc[i] - rcyc[i-1]);
        end
      end
    end
    n_cmp++; if (ir !== 32'h33) begin n_fail++; $display("FAIL arith_ir got %h want 33", ir); end
  endtask

  task automatic test_load_wait();
    build_trace(32'h0040_2083, 0, 2, 1'b0, 1'b0);
    run_trace();
    foreach (exp_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ld_wait c%0d got %b want %b", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (ir !== 32'h0040_2083) begin n_fail++; $display("FAIL ld_ir got %h want 00402083", ir); end
    n_cmp++; if (instret !== instret_exp()) begin n_fail++; $display("FAIL ld_instret got %h want %h", instret, instret_exp()); end
  endtask

  task automatic test_branch();
    logic [31:0] brs[4];
    logic        cs[4];
    brs = '{32'h00A0_0063, 32'h00A0_0063, 32'h0040_806B, 32'h0040_806B};
    cs  = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int n = 0; n < 4; n++) begin
      build_trace(brs[n], int'($urandom_range(0, 2)), 0, cs[n], 1'b0);
      run_trace();
      foreach (exp_q[i]) begin
        n_cmp++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL branch n%0d c%0d got %b want %b", n, i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      build_trace(rand_legal(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'b0);
      run_trace();
      foreach (exp_q[i]) begin
        n_cmp++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL random n%0d ir=%h c%0d got %b want %b", n, rd_q[$], i, obs_q[i], exp_q[i]);
        end
      end
    end
    n_cmp++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL random_illegal got %b want 0", illegal); end
    n_cmp++; if (instret !== instret_exp()) begin n_fail++; $display("FAIL random_instret got %h want %h", instret, instret_exp()); end
  endtask

  task automatic test_trap();
    logic [31:0] bad[5];
    bad = '{32'h0000_007F, 32'h0000_3023, 32'h0000_7023, 32'h0000_3003, 32'hDEAD_B00B};
    for (int n = 0; n < 5; n++) begin
      do_reset();
      build_trace(bad[n], int'($urandom_range(0, 1)), 0, 1'b0, 1'b0);
      run_trace();
      foreach (exp_q[i]) begin
        n_cmp++;
        if (obs_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL trap n%0d c%0d got %b want %b", n, i, obs_q[i], exp_q[i]);
        end
      end
      n_cmp++; if (illegal !== 1'b1) begin n_fail++; $display("FAIL trap_illegal n%0d got %b want 1", n, illegal); end
      n_cmp++; if (ir !== bad[n]) begin n_fail++; $display("FAIL trap_ir n%0d got %h want %h", n, ir, bad[n]); end
    end
  endtask

  task automatic test_reset_mid_fetch();
    do_reset();
    n_cmp++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL rst_clears_illegal got %b want 0", illegal); end
    build_trace(32'h1234_5033, 0, 0, 1'b0, 1'b1);
    run_trace();
    step(1'b0, 32'h0, 1'b0);
    n_cmp++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL midfetch_req got %b want 1", bus_req); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL midfetch_async_req got %b want 0", bus_req); end
    n_cmp++; if (ir !== 32'h0) begin n_fail++; $display("FAIL midfetch_ir got %h want 0", ir); end
    @(negedge clk);
    bus_ack = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL midfetch_hold_req got %b want 0", bus_req); end
    rst = 1'b0; exp_ret = 0; cyc = 1;
    n_cmp++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL midfetch_idle_req got %b want 0", bus_req); end
    build_trace(32'h0000_0000, 0, 0, 1'b0, 1'b1);
    run_trace();
    foreach (exp_q[i]) begin
      n_cmp++;
      if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL restart c%0d got %b want %b", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (cyc_q[0] != 2) begin n_fail++; $display("FAIL restart_fetch_cycle got %0d want 2", cyc_q[0]); end
  endtask

  task automatic test_perf();
    do_reset();
`ifdef INSTR_SEQ_PERF_EN
    dut.instret_q = 32'hFFFF_FFFF;
    exp_ret = -1;
`endif
    build_trace(32'h0000_0000, 0, 0, 1'b0, 1'b0);
    run_trace();
    @(negedge clk); #1;
    n_cmp++; if (instret !== instret_exp()) begin n_fail++; $display("FAIL perf_wrap got %h want %h", instret, instret_exp()); end
    n_cmp++; if (instret !== 32'h0) begin n_fail++; $display("FAIL perf_zero got %h want 0", instret); end
  endtask

  initial begin
    test_reset();
    test_arith_tied_ack();
    test_load_wait();
    test_branch();
    test_random();
    test_trap();
    test_reset_mid_fetch();
    test_perf();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
